// File: rtl/box_render_if.sv
// Video stream bundle between the sync generator / display side and box_render.
// master drives timing and pixel coordinates; slave returns the coloured, re-aligned stream.
interface box_render_if;
    logic       H_Sync_in;
    logic       V_Sync_in;
    logic       Active_Zone;
    logic [9:0] X_pos;
    logic [9:0] Y_pos;
    logic       Pause;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;
    logic       H_Sync_out;
    logic       V_Sync_out;
    logic [7:0] Bounce_Count;

    modport master (
        output H_Sync_in, V_Sync_in, Active_Zone, X_pos, Y_pos, Pause,
        input  R, G, B, H_Sync_out, V_Sync_out, Bounce_Count
    );

    modport slave (
        input  H_Sync_in, V_Sync_in, Active_Zone, X_pos, Y_pos, Pause,
        output R, G, B, H_Sync_out, V_Sync_out, Bounce_Count
    );
endinterface

// File: rtl/box_render.sv
// Bouncing-square overlay: draws a palette-coloured box over a checkerboard and moves it
// once per frame during vertical blanking, counting wall hits.
module box_render #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned BOX_SIZE  = 64,
    parameter int unsigned STEP      = 4
) (
    input logic         CLOCK,
    input logic         RESET,
    box_render_if.slave vid
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RUN        = 2'd1,
        HOLD       = 2'd2
    } state_e;

    // Positions are kept in 11 bits so limit compares never wrap.
    localparam logic [10:0] X_MAX   = 11'(H_VISIBLE - BOX_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_VISIBLE - BOX_SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);
    localparam logic [10:0] X_START = 11'((H_VISIBLE - BOX_SIZE) / 2);
    localparam logic [10:0] Y_START = 11'((V_VISIBLE - BOX_SIZE) / 2);

    state_e      state_q, state_d;
    logic [10:0] box_x_q, box_x_d;
    logic [10:0] box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;   // 0 = right
    logic        dir_y_q, dir_y_d;   // 0 = down
    logic [2:0]  color_idx_q, color_idx_d;
    logic [7:0]  bounce_count_q, bounce_count_d;

    logic [11:0] rgb_q, rgb_d;
    logic        h_sync_q;
    logic        v_sync_q;           // doubles as the previous-V_Sync sample for edge detect

    logic        tick;
    logic        move;
    logic [11:0] next_x;
    logic [11:0] next_y;
    logic        in_box;

    // Returns {flip, new_position} for one axis.
    function automatic logic [11:0] axis_next(input logic [10:0] pos, input logic neg,
                                              input logic [10:0] lim);
        logic [10:0] sum;
        sum = pos + STEP_W;
        if (!neg) begin
            if (sum >= lim) begin
                axis_next = {1'b1, lim};
            end else begin
                axis_next = {1'b0, sum};
            end
        end else begin
            if (pos <= STEP_W) begin
                axis_next = {1'b1, 11'd0};
            end else begin
                axis_next = {1'b0, pos - STEP_W};
            end
        end
    endfunction

    function automatic logic [11:0] palette(input logic [2:0] idx);
        logic [11:0] c;
        unique case (idx)
            3'd0: c = 12'hFFF;
            3'd1: c = 12'hF00;
            3'd2: c = 12'h0F0;
            3'd3: c = 12'h00F;
            3'd4: c = 12'hFF0;
            3'd5: c = 12'h0FF;
            3'd6: c = 12'hF0F;
            3'd7: c = 12'hF80;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    assign tick   = v_sync_q & ~vid.V_Sync_in;
    assign next_x = axis_next(box_x_q, dir_x_q, X_MAX);
    assign next_y = axis_next(box_y_q, dir_y_q, Y_MAX);

    always_comb begin
        state_d = state_q;
        move    = 1'b0;
        unique case (state_q)
            WAIT_FRAME: begin
                if (tick) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (vid.Pause) begin
                        state_d = HOLD;
                    end else begin
                        move = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick && !vid.Pause) begin
                    state_d = RUN;
                    move    = 1'b1;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_comb begin
        box_x_d        = box_x_q;
        box_y_d        = box_y_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        color_idx_d    = color_idx_q;
        bounce_count_d = bounce_count_q;
        if (move) begin
            box_x_d = next_x[10:0];
            box_y_d = next_y[10:0];
            dir_x_d = dir_x_q ^ next_x[11];
            dir_y_d = dir_y_q ^ next_y[11];
            // A corner hit flips both axes but is a single bounce.
            if (next_x[11] || next_y[11]) begin
                color_idx_d    = color_idx_q + 3'd1;
                bounce_count_d = bounce_count_q + 8'd1;
            end
        end
    end

    always_comb begin
        in_box = vid.Active_Zone
                 && ({1'b0, vid.X_pos} >= box_x_q) && ({1'b0, vid.X_pos} < box_x_q + SIZE_W)
                 && ({1'b0, vid.Y_pos} >= box_y_q) && ({1'b0, vid.Y_pos} < box_y_q + SIZE_W);
        rgb_d = 12'h000;
        if (vid.Active_Zone) begin
            if (in_box) begin
                rgb_d = palette(color_idx_q);
            end else if (vid.X_pos[5] ^ vid.Y_pos[5]) begin
                rgb_d = 12'h222;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= WAIT_FRAME;
            box_x_q        <= X_START;
            box_y_q        <= Y_START;
            dir_x_q        <= 1'b0;
            dir_y_q        <= 1'b0;
            color_idx_q    <= 3'd0;
            bounce_count_q <= 8'd0;
            rgb_q          <= 12'h000;
            h_sync_q       <= 1'b1;
            v_sync_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            box_x_q        <= box_x_d;
            box_y_q        <= box_y_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            color_idx_q    <= color_idx_d;
            bounce_count_q <= bounce_count_d;
            rgb_q          <= rgb_d;
            h_sync_q       <= vid.H_Sync_in;
            v_sync_q       <= vid.V_Sync_in;
        end
    end

    assign vid.R            = rgb_q[11:8];
    assign vid.G            = rgb_q[7:4];
    assign vid.B            = rgb_q[3:0];
    assign vid.H_Sync_out   = h_sync_q;
    assign vid.V_Sync_out   = v_sync_q;
    assign vid.Bounce_Count = bounce_count_q;

endmodule
